aud_recorder: RTL and testbench

AUD_RECORDER -- requirements
Module: aud_recorder

---
 rtl/aud_pkg.sv | 24 ++
 rtl/aud_edge_sync.sv | 51 +++++
 rtl/aud_recorder.sv | 177 +++++++++++++++++
 tb/tb_aud_recorder.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/aud_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aud_pkg
// Brief    : Shared types and constants for the I2S audio recorder.
// Revision : 1.0 - initial release
// ============================================================================
package aud_pkg;

  localparam int ADDR_W    = 20;
  localparam int SAMPLE_W  = 16;
  localparam int SKIP_BITS = 1;
  localparam int BIT_CNT_W = 5;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_LRC = 3'd1,
    ST_SKIP     = 3'd2,
    ST_SHIFT    = 3'd3,
    ST_WRITE    = 3'd4,
    ST_PAUSED   = 3'd5
  } state_t;

endpackage
`default_nettype wire

// File: rtl/aud_edge_sync.sv
`default_nettype none
// ============================================================================
// Module   : aud_edge_sync
// Brief    : Synchroniser plus rise/fall detect for one codec-domain signal.
//            AUD_REC_SYNC2_EN selects a two-flop synchroniser (else one flop).
// Revision : 1.0 - initial release
// ============================================================================
module aud_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic i_sig,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic sync_q;
  logic prev_q;

`ifdef AUD_REC_SYNC2_EN
  logic meta_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= i_sig;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end
`else
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= i_sig;
      prev_q <= sync_q;
    end
  end
`endif

  assign o_level = sync_q;
  assign o_rise  = sync_q & ~prev_q;
  assign o_fall  = ~sync_q & prev_q;

endmodule
`default_nettype wire

// File: rtl/aud_recorder.sv
`default_nettype none
// ============================================================================
// Module   : aud_recorder
// Brief    : Captures left-channel I2S samples from a codec and writes them to
//            SRAM. Build macro AUD_REC_SYNC2_EN deepens the input synchroniser.
// Revision : 1.0 - initial release
// ============================================================================
module aud_recorder
  import aud_pkg::*;
#(
  parameter int ADDR_W   = aud_pkg::ADDR_W,
  parameter int SAMPLE_W = aud_pkg::SAMPLE_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_init_done,
  input  logic                i_start,
  input  logic                i_pause,
  input  logic                i_stop,
  input  logic                i_bclk,
  input  logic                i_lrc,
  input  logic                i_adcdat,
  output logic [ADDR_W-1:0]   o_address,
  output logic [SAMPLE_W-1:0] o_data,
  output logic                o_we,
  output logic [ADDR_W-1:0]   o_len,
  output logic                o_busy
);

  // Recording halts after this address is written, so o_len saturates at 2^ADDR_W-1
  localparam logic [ADDR_W-1:0]    LAST_ADDR = ADDR_W'((2 ** ADDR_W) - 2);
  localparam logic [BIT_CNT_W-1:0] SKIP_END  = BIT_CNT_W'(SKIP_BITS - 1);
  localparam logic [BIT_CNT_W-1:0] SHIFT_END = BIT_CNT_W'(SAMPLE_W - 1);

  state_t                state_q, state_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [ADDR_W-1:0]     len_q, len_d;
  logic [SAMPLE_W-1:0]   sample_q, sample_d;
  logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic                  pause_pend_q, pause_pend_d;
  logic                  init_q, init_d;

  logic bclk_level, bclk_rise, bclk_fall;
  logic lrc_level, lrc_rise, lrc_fall;
  logic dat_level, dat_rise, dat_fall;
  logic unused_sync;

  aud_edge_sync u_sync_bclk (
    .clk(clk), .rst(rst), .i_sig(i_bclk),
    .o_level(bclk_level), .o_rise(bclk_rise), .o_fall(bclk_fall)
  );

  aud_edge_sync u_sync_lrc (
    .clk(clk), .rst(rst), .i_sig(i_lrc),
    .o_level(lrc_level), .o_rise(lrc_rise), .o_fall(lrc_fall)
  );

  aud_edge_sync u_sync_dat (
    .clk(clk), .rst(rst), .i_sig(i_adcdat),
    .o_level(dat_level), .o_rise(dat_rise), .o_fall(dat_fall)
  );

  assign unused_sync = ^{bclk_level, bclk_fall, lrc_level, lrc_rise, dat_rise, dat_fall};

  logic cmd_start, cmd_pause, cmd_stop;
  assign cmd_start = i_start & init_q;
  assign cmd_pause = i_pause & init_q;
  assign cmd_stop  = i_stop  & init_q;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    len_d        = len_q;
    sample_d     = sample_q;
    bit_cnt_d    = bit_cnt_q;
    pause_pend_d = pause_pend_q;
    init_d       = init_q | i_init_done;

    case (state_q)
      ST_IDLE: begin
        if (cmd_start && !cmd_pause && !cmd_stop) begin
          state_d      = ST_WAIT_LRC;
          addr_d       = '0;
          len_d        = '0;
          pause_pend_d = 1'b0;
        end
      end
      ST_WAIT_LRC: begin
        if (cmd_stop) begin
          state_d = ST_IDLE;
        end else if (cmd_pause) begin
          state_d = ST_PAUSED;
        end else if (lrc_fall) begin
          state_d   = ST_SKIP;
          bit_cnt_d = '0;
        end
      end
      ST_SKIP: begin
        if (cmd_stop) begin
          state_d      = ST_IDLE;
          pause_pend_d = 1'b0;
        end else begin
          if (cmd_pause) pause_pend_d = 1'b1;
          if (bclk_rise) begin
            if (bit_cnt_q == SKIP_END) begin
              state_d   = ST_SHIFT;
              bit_cnt_d = '0;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
        end
      end
      ST_SHIFT: begin
        if (cmd_stop) begin
          state_d      = ST_IDLE;
          pause_pend_d = 1'b0;
        end else begin
          if (cmd_pause) pause_pend_d = 1'b1;
          if (bclk_rise) begin
            sample_d  = {sample_q[SAMPLE_W-2:0], dat_level};
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == SHIFT_END) state_d = ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        addr_d       = addr_q + 1'b1;
        len_d        = len_q + 1'b1;
        pause_pend_d = 1'b0;
        if (cmd_stop || addr_q == LAST_ADDR) begin
          state_d = ST_IDLE;
        end else if (pause_pend_q || cmd_pause) begin
          state_d = ST_PAUSED;
        end else begin
          state_d = ST_WAIT_LRC;
        end
      end
      ST_PAUSED: begin
        if (cmd_stop) begin
          state_d = ST_IDLE;
        end else if (cmd_start && !cmd_pause) begin
          state_d = ST_WAIT_LRC;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      len_q        <= '0;
      sample_q     <= '0;
      bit_cnt_q    <= '0;
      pause_pend_q <= 1'b0;
      init_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      sample_q     <= sample_d;
      bit_cnt_q    <= bit_cnt_d;
      pause_pend_q <= pause_pend_d;
      init_q       <= init_d;
    end
  end

  assign o_address = addr_q;
  assign o_data    = sample_q;
  assign o_we      = (state_q == ST_WRITE);
  assign o_len     = len_q;
  assign o_busy    = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_aud_recorder.sv
`default_nettype none
// ============================================================================
// Module   : tb_aud_recorder
// Brief    : Self-checking bench: I2S serial model driving a 20-bit recorder
//            and a 4-bit-address recorder for the full-memory case.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aud_recorder;

  logic        clk = 1'b0;
  logic        rst;
  logic        init_done, bclk, lrc, dat;
  logic        a_start, a_pause, a_stop, b_start;
  logic [19:0] a_addr, a_len;
  logic [15:0] a_data, b_data;
  logic        a_we, a_busy, b_we, b_busy;
  logic [3:0]  b_addr, b_len;

  int n_tests = 0;
  int n_fail  = 0;
  int a_wr_cnt = 0;
  int b_wr_cnt = 0;
  logic [15:0] a_wr_data[$];
  logic [19:0] a_wr_addr[$];
  logic [15:0] b_wr_data[$];
  logic [3:0]  b_wr_addr[$];
  logic        cmd_busy;

  always #5 clk = ~clk;

  aud_recorder #(.ADDR_W(20), .SAMPLE_W(16)) u_dut_a (
    .clk(clk), .rst(rst), .i_init_done(init_done),
    .i_start(a_start), .i_pause(a_pause), .i_stop(a_stop),
    .i_bclk(bclk), .i_lrc(lrc), .i_adcdat(dat),
    .o_address(a_addr), .o_data(a_data), .o_we(a_we), .o_len(a_len), .o_busy(a_busy)
  );

  aud_recorder #(.ADDR_W(4), .SAMPLE_W(16)) u_dut_b (
    .clk(clk), .rst(rst), .i_init_done(init_done),
    .i_start(b_start), .i_pause(1'b0), .i_stop(1'b0),
    .i_bclk(bclk), .i_lrc(lrc), .i_adcdat(dat),
    .o_address(b_addr), .o_data(b_data), .o_we(b_we), .o_len(b_len), .o_busy(b_busy)
  );

  always @(negedge clk) begin
    if (a_we === 1'b1) begin
      a_wr_cnt++;
      a_wr_data.push_back(a_data);
      a_wr_addr.push_back(a_addr);
    end
    if (b_we === 1'b1) begin
      b_wr_cnt++;
      b_wr_data.push_back(b_data);
      b_wr_addr.push_back(b_addr);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_a(input logic [2:0] cmd);
    {a_stop, a_pause, a_start} = cmd;
    tick(1);
    {a_stop, a_pause, a_start} = 3'b000;
  endtask

  // One I2S frame of 32 bclk periods (8 clk each); left MSB follows the skip bit.
  // cmd = {stop,pause,start} is pulsed at the start of bclk period cmd_bit.
  task automatic send_frame(input logic [15:0] left, input int cmd_bit,
                            input logic [2:0] cmd, input int ncyc);
    for (int k = 0; k < ncyc; k++) begin
      lrc  = (k >= 16);
      dat  = (k >= 1 && k <= 16) ? left[4'(16 - k)] : 1'b0;
      bclk = 1'b0;
      if (k == cmd_bit) begin
        {a_stop, a_pause, a_start} = cmd;
        tick(1);
        {a_stop, a_pause, a_start} = 3'b000;
        @(negedge clk);
        cmd_busy = a_busy;
        tick(3);
      end else begin
        tick(4);
      end
      bclk = 1'b1;
      tick(4);
    end
  endtask

  typedef struct {
    logic [15:0] left;
    int          cmd_bit;
    logic [2:0]  cmd;
    logic        exp_busy_cmd;
    int          exp_nw;
    logic [19:0] exp_addr;
    logic [19:0] exp_len;
    logic        exp_busy;
  } vec_t;

  vec_t tbl[9];

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nw0;
    tbl[0] = '{16'h1234, -1, 3'b000, 1'b0, 1, 20'd0, 20'd1, 1'b1};
    tbl[1] = '{16'h8001,  8, 3'b001, 1'b1, 1, 20'd1, 20'd2, 1'b1};
    tbl[2] = '{16'hBEEF,  8, 3'b010, 1'b1, 1, 20'd2, 20'd3, 1'b1};
    tbl[3] = '{16'h5555, 20, 3'b001, 1'b1, 0, 20'd0, 20'd3, 1'b1};
    tbl[4] = '{16'h0F0F, -1, 3'b000, 1'b0, 1, 20'd3, 20'd4, 1'b1};
    tbl[5] = '{16'hFFFF,  5, 3'b100, 1'b0, 0, 20'd0, 20'd4, 1'b0};
    tbl[6] = '{16'h0000, 20, 3'b001, 1'b1, 0, 20'd0, 20'd0, 1'b1};
    tbl[7] = '{16'h7FFE, -1, 3'b000, 1'b0, 1, 20'd0, 20'd1, 1'b1};
    tbl[8] = '{16'hC3C3,  5, 3'b111, 1'b0, 0, 20'd0, 20'd1, 1'b0};

    rst = 1'b0; init_done = 1'b0;
    a_start = 1'b0; a_pause = 1'b0; a_stop = 1'b0; b_start = 1'b0;
    bclk = 1'b0; lrc = 1'b1; dat = 1'b0; cmd_busy = 1'b0;
    tick(3);
    rst = 1'b1;
    @(negedge clk);
    check("reset busy", a_busy, 0);
    check("reset we", a_we, 0);
    check("reset addr", a_addr, 0);
    check("reset data", a_data, 0);
    check("reset len", a_len, 0);
    tick(1);

    // Commands before init completes are ignored
    pulse_a(3'b001);
    tick(2);
    @(negedge clk);
    check("init gate busy", a_busy, 0);
    tick(1);
    init_done = 1'b1;
    tick(1);
    pulse_a(3'b001);
    @(negedge clk);
    check("start busy", a_busy, 1);
    tick(1);

    send_frame(16'hA5C3, -1, 3'b000, 32);
    @(negedge clk);
    check("single nwrites", a_wr_cnt, 1);
    check("single data", a_wr_data[0], 16'hA5C3);
    check("single addr", a_wr_addr[0], 0);
    check("single len", a_len, 1);
    tick(1);

    pulse_a(3'b100);
    @(negedge clk);
    check("stop busy", a_busy, 0);
    tick(1);
    pulse_a(3'b001);

    for (int r = 0; r < 9; r++) begin
      nw0 = a_wr_cnt;
      send_frame(tbl[r].left, tbl[r].cmd_bit, tbl[r].cmd, 32);
      @(negedge clk);
      if (tbl[r].cmd != 3'b000)
        check($sformatf("row%0d busy_after_cmd", r), cmd_busy, tbl[r].exp_busy_cmd);
      check($sformatf("row%0d nwrites", r), a_wr_cnt - nw0, tbl[r].exp_nw);
      if (tbl[r].exp_nw != 0 && a_wr_cnt > nw0) begin
        check($sformatf("row%0d data", r), a_wr_data[a_wr_cnt-1], tbl[r].left);
        check($sformatf("row%0d addr", r), a_wr_addr[a_wr_cnt-1], tbl[r].exp_addr);
      end
      check($sformatf("row%0d len", r), a_len, tbl[r].exp_len);
      check($sformatf("row%0d busy", r), a_busy, tbl[r].exp_busy);
      tick(1);
    end

    // Reset in the middle of a sample clears everything without a write
    pulse_a(3'b001);
    send_frame(16'h2468, -1, 3'b000, 32);
    send_frame(16'hF0F0, -1, 3'b000, 7);
    nw0 = a_wr_cnt;
    rst = 1'b0;
    #1;
    check("rst mid busy", a_busy, 0);
    check("rst mid we", a_we, 0);
    check("rst mid addr", a_addr, 0);
    check("rst mid data", a_data, 0);
    check("rst mid len", a_len, 0);
    tick(2);
    lrc = 1'b1; bclk = 1'b0;
    tick(2);
    rst = 1'b1;
    tick(8);
    send_frame(16'h1111, -1, 3'b000, 32);
    @(negedge clk);
    check("rst no resume nwrites", a_wr_cnt - nw0, 0);
    check("rst no resume busy", a_busy, 0);
    tick(1);

    // Full memory on the 4-bit-address instance
    b_start = 1'b1;
    tick(1);
    b_start = 1'b0;
    for (int i = 0; i < 20; i++) send_frame(16'h1000 + 16'(i), -1, 3'b000, 32);
    @(negedge clk);
    check("full nwrites", b_wr_cnt, 15);
    for (int i = 0; i < 15; i++) begin
      check($sformatf("full addr%0d", i), b_wr_addr[i], i);
      check($sformatf("full data%0d", i), b_wr_data[i], 16'h1000 + i);
    end
    check("full len", b_len, 15);
    check("full busy", b_busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
